// File: rtl/bridge_utils_pkg.sv
// Shared types and the burst address helper for the AXI2APB bridge.
// The WRAP address rule is compiled only when AXI_RD_WRAP_EN is defined.
package bridge_utils;

   localparam int ID_WIDTH_DEF   = 4;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_CALC_W    = 64;

   typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_t;
   typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, ERR, DRAIN} rd_state_t;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] data;
      resp_t                     resp;
      logic                      last;
   } rbeat_t;

   // Computed at a fixed 64-bit width; callers truncate to their address width.
   function automatic logic [ADDR_CALC_W-1:0] next_addr(
      input logic [ADDR_CALC_W-1:0] addr,
      input logic [2:0]             size,
      input logic [3:0]             len,
      input burst_t                 burst
   );
      logic [ADDR_CALC_W-1:0] inc;
`ifdef AXI_RD_WRAP_EN
      logic [ADDR_CALC_W-1:0] mask;
`else
      logic                   len_unused;
`endif
      inc = ADDR_CALC_W'(1) << size;
`ifdef AXI_RD_WRAP_EN
      mask = ((ADDR_CALC_W'(len) + ADDR_CALC_W'(1)) << size) - ADDR_CALC_W'(1);
`else
      len_unused = ^len;
`endif
      case (burst)
         INCR:    next_addr = addr + inc;
`ifdef AXI_RD_WRAP_EN
         WRAP:    next_addr = (addr & ~mask) | ((addr + inc) & mask);
`endif
         default: next_addr = addr;
      endcase
   endfunction

endpackage

// File: rtl/bridge_fifo2.sv
// Two-entry FIFO of read beats; simultaneous push and pop are both honoured.
module bridge_fifo2
   import bridge_utils::*;
#(
   parameter type beat_t = rbeat_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  logic       pop_i,
   input  beat_t      data_i,
   output beat_t      head_o,
   output logic       full_o,
   output logic       empty_o,
   output logic [1:0] count_o
);

   beat_t      mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign do_pop  = pop_i && (count_q != 2'd0);
   assign do_push = push_i && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: only two entries, and the head drives rdata/rresp directly,
         // so the storage is reset to give defined R outputs out of reset.
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;

endmodule

// File: rtl/slave_axi_read_responder.sv
// AXI3 read-path responder of the AXI2APB bridge: one AR burst becomes per-beat engine reads.
// Define AXI_RD_WRAP_EN to accept WRAP bursts; otherwise they are answered with SLVERR beats.
module slave_axi_read_responder
   import bridge_utils::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ID_WIDTH-1:0]   arid,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [3:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [ID_WIDTH-1:0]   rid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic                  rd_grant,
   output logic                  rd_busy,
   output logic                  eng_req_valid,
   input  logic                  eng_req_ready,
   output logic [ADDR_WIDTH-1:0] eng_req_addr,
   input  logic                  eng_rsp_valid,
   input  logic [DATA_WIDTH-1:0] eng_rsp_data,
   input  logic                  eng_rsp_err
);

   localparam int SIZE_MAX = $clog2(DATA_WIDTH / 8);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      resp_t                 resp;
      logic                  last;
   } beat_t;

   rd_state_t             state_q;
   logic                  out_en_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            len_q;
   logic [3:0]            beats_left_q;
   logic [2:0]            size_q;
   burst_t                burst_q;

   logic                  ar_hs;
   logic                  ar_illegal;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [1:0]            fifo_count;
   beat_t                 push_beat;
   beat_t                 head_beat;

`ifdef AXI_RD_WRAP_EN
   logic wrap_len_ok;
   assign wrap_len_ok = (arlen == 4'd1) || (arlen == 4'd3) || (arlen == 4'd7) || (arlen == 4'd15);
   assign ar_illegal  = (arburst == 2'd3) || (arsize > 3'(SIZE_MAX)) ||
                        ((arburst == WRAP) && !wrap_len_ok);
`else
   assign ar_illegal  = (arburst == 2'd3) || (arsize > 3'(SIZE_MAX)) || (arburst == WRAP);
`endif

   // out_en_q keeps arready low while reset is asserted, whatever rd_grant does.
   assign arready       = (state_q == IDLE) && rd_grant && out_en_q;
   assign ar_hs         = arvalid && arready;
   assign rd_busy       = (state_q != IDLE);
   assign eng_req_valid = (state_q == REQ) && (fifo_count < 2'd2);
   assign eng_req_addr  = addr_q;
   assign addr_d        = ADDR_WIDTH'(next_addr(ADDR_CALC_W'(addr_q), size_q, len_q, burst_q));

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can infer a latch.
      fifo_push = 1'b0;
      push_beat = '0;
      case (state_q)
         WAIT: begin
            if (eng_rsp_valid) begin
               fifo_push      = 1'b1;
               push_beat.data = eng_rsp_data;
               push_beat.resp = eng_rsp_err ? SLVERR : OKAY;
               push_beat.last = (beats_left_q == 4'd0);
            end
         end
         ERR: begin
            if (!fifo_full) begin
               fifo_push      = 1'b1;
               push_beat.resp = SLVERR;
               push_beat.last = (beats_left_q == 4'd0);
            end
         end
         default: ;
      endcase
   end

   assign fifo_pop = rvalid && rready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         out_en_q     <= 1'b0;
         id_q         <= '0;
         addr_q       <= '0;
         len_q        <= 4'd0;
         size_q       <= 3'd0;
         burst_q      <= FIXED;
         beats_left_q <= 4'd0;
      end else begin
         // NOTE: state is updated with non-blocking assignments only, so every
         // branch below sees the values from before this edge.
         out_en_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (ar_hs) begin
                  id_q         <= arid;
                  addr_q       <= araddr;
                  len_q        <= arlen;
                  size_q       <= arsize;
                  burst_q      <= burst_t'(arburst);
                  beats_left_q <= arlen;
                  state_q      <= ar_illegal ? ERR : REQ;
               end
            end
            REQ: begin
               if (eng_req_valid && eng_req_ready) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (eng_rsp_valid) begin
                  if (beats_left_q == 4'd0) begin
                     state_q <= DRAIN;
                  end else begin
                     beats_left_q <= beats_left_q - 4'd1;
                     addr_q       <= addr_d;
                     state_q      <= REQ;
                  end
               end
            end
            ERR: begin
               if (!fifo_full) begin
                  if (beats_left_q == 4'd0) begin
                     state_q <= DRAIN;
                  end else begin
                     beats_left_q <= beats_left_q - 4'd1;
                  end
               end
            end
            DRAIN: begin
               // Leave as the last beat is popped so rd_busy drops with that pop.
               if (fifo_empty || ((fifo_count == 2'd1) && fifo_pop)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   bridge_fifo2 #(
      .beat_t (beat_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (push_beat),
      .head_o  (head_beat),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rid    = id_q;
   assign rvalid = !fifo_empty;
   assign rdata  = head_beat.data;
   assign rresp  = head_beat.resp;
   assign rlast  = head_beat.last;

endmodule
